// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl
// ----------------------------------------------------------------------------
// LC-3 memory access controller. Owns MAR and MDR, sequences a fixed
// wait-state access to external memory for each rising edge of memEn, and
// returns a one-cycle ready pulse (R) to the control FSM.
//
// Optional feature macro: MMIO_EN
//   When defined, the keyboard/display device registers at xFE00 (KBSR),
//   xFE02 (KBDR), xFE04 (DSR) and xFE06 (DDR) are served internally and
//   never reach external memory. When undefined, the device ports are absent
//   and every address goes to external memory.
//
// Parameters
//   WAIT_CYCLES : cycles memReq is held per access, legal range 1..15
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-low reset
//   Bus       in   datapath bus, source for MAR and (mioEn=0) MDR
//   ldMAR     in   load MAR from Bus (ignored during ACCESS)
//   ldMDR     in   load MDR from Bus when mioEn=0 (ignored during ACCESS)
//   mioEn     in   MDR source select: 1 = memory path, 0 = Bus
//   memEn     in   access request, rising edge starts one access
//   rw        in   1 = write, 0 = read, sampled with the memEn rising edge
//   memRdata  in   external read data, valid on the last ACCESS cycle
//   MAROut    out  MAR contents
//   MDROut    out  MDR contents
//   R         out  access complete, one-cycle pulse
//   memReq    out  external request, held for the whole access
//   memWe     out  external write enable (latched rw while memReq=1)
//   memAddr   out  always MAROut
//   memWdata  out  always MDROut
//   kbData    in   (MMIO_EN) keyboard data
//   kbValid   in   (MMIO_EN) keyboard data strobe
//   dsrReady  in   (MMIO_EN) display ready status
//   ddrOut    out  (MMIO_EN) display data register
//   ddrWr     out  (MMIO_EN) display write pulse
// ============================================================================
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] Bus,
    input  logic        ldMAR,
    input  logic        ldMDR,
    input  logic        mioEn,
    input  logic        memEn,
    input  logic        rw,
    input  logic [15:0] memRdata,
`ifdef MMIO_EN
    input  logic [7:0]  kbData,
    input  logic        kbValid,
    input  logic        dsrReady,
    output logic [7:0]  ddrOut,
    output logic        ddrWr,
`endif
    output logic [15:0] MAROut,
    output logic [15:0] MDROut,
    output logic        R,
    output logic        memReq,
    output logic        memWe,
    output logic [15:0] memAddr,
    output logic [15:0] memWdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

`ifdef MMIO_EN
    localparam logic [15:0] ADDR_KBSR = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR = 16'hFE02;
    localparam logic [15:0] ADDR_DSR  = 16'hFE04;
    localparam logic [15:0] ADDR_DDR  = 16'hFE06;
`endif

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rw_q, rw_d;
    logic        memen_prev_q, memen_prev_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;

    logic        start_s;      // memEn rising edge seen while idle
    logic        mmio_hit_s;   // current (possibly just-loaded) MAR is a device register
    logic [15:0] mdr_bus_s;    // MDR value after an ordinary Bus load outside ACCESS
    logic [15:0] mmio_rdata_s; // device register read value

`ifdef MMIO_EN
    logic        kb_ready_q, kb_ready_d;
    logic [7:0]  kb_data_q, kb_data_d;
    logic [7:0]  ddr_out_q, ddr_out_d;
    logic        ddr_wr_q, ddr_wr_d;
`endif

    // Access-start detection and device address decode
    always_comb begin
        start_s      = 1'b0;
        mmio_hit_s   = 1'b0;
        mmio_rdata_s = 16'h0000;
        if ((state_q == ST_IDLE) && memEn && !memen_prev_q) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
`ifdef MMIO_EN
        // Decode uses mar_d so an ldMAR in the start cycle selects the target
        case (mar_d)
            ADDR_KBSR: begin
                mmio_hit_s   = 1'b1;
                mmio_rdata_s = {kb_ready_q, 15'h0000};
            end
            ADDR_KBDR: begin
                mmio_hit_s   = 1'b1;
                mmio_rdata_s = {8'h00, kb_data_q};
            end
            ADDR_DSR: begin
                mmio_hit_s   = 1'b1;
                mmio_rdata_s = {dsrReady, 15'h0000};
            end
            ADDR_DDR: begin
                mmio_hit_s   = 1'b1;
                mmio_rdata_s = 16'h0000;
            end
            default: begin
                mmio_hit_s   = 1'b0;
                mmio_rdata_s = 16'h0000;
            end
        endcase
`endif
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state, wait counter and latched direction
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    rw_d = rw;
                    if (mmio_hit_s) begin
                        // Device registers complete without an external cycle
                        state_d = ST_DONE;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = WAIT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM outputs, decoded from registered state only
    always_comb begin
        memReq = 1'b0;
        memWe  = 1'b0;
        R      = 1'b0;
        case (state_q)
            ST_ACCESS: begin
                memReq = 1'b1;
                memWe  = rw_q;
            end
            ST_DONE: begin
                R = 1'b1;
            end
            default: begin
                memReq = 1'b0;
                memWe  = 1'b0;
                R      = 1'b0;
            end
        endcase
    end

    // MAR/MDR next values; both registers are locked while ACCESS is active
    always_comb begin
        memen_prev_d = memEn;
        mar_d        = mar_q;
        mdr_bus_s    = mdr_q;
        mdr_d        = mdr_q;
        if (state_q == ST_ACCESS) begin
            mar_d     = mar_q;
            mdr_bus_s = mdr_q;
            if ((cnt_q == 4'd0) && !rw_q) begin
                mdr_d = memRdata;
            end else begin
                mdr_d = mdr_q;
            end
        end else begin
            if (ldMAR) begin
                mar_d = Bus;
            end else begin
                mar_d = mar_q;
            end
            // mioEn=1 loads are owned by the FSM, so only the Bus path is here
            if (ldMDR && !mioEn) begin
                mdr_bus_s = Bus;
            end else begin
                mdr_bus_s = mdr_q;
            end
            // A device read in the start cycle takes priority over a Bus load
            if (start_s && mmio_hit_s && !rw) begin
                mdr_d = mmio_rdata_s;
            end else begin
                mdr_d = mdr_bus_s;
            end
        end
    end

    // Datapath registers and memEn history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= 4'd0;
            rw_q         <= 1'b0;
            memen_prev_q <= 1'b0;
            mar_q        <= 16'h0000;
            mdr_q        <= 16'h0000;
        end else begin
            cnt_q        <= cnt_d;
            rw_q         <= rw_d;
            memen_prev_q <= memen_prev_d;
            mar_q        <= mar_d;
            mdr_q        <= mdr_d;
        end
    end

`ifdef MMIO_EN
    // Keyboard status/data and display register next values
    always_comb begin
        kb_ready_d = kb_ready_q;
        kb_data_d  = kb_data_q;
        ddr_out_d  = ddr_out_q;
        ddr_wr_d   = 1'b0;
        // A new keystroke on the same edge as a KBDR read keeps kbReady set
        if (kbValid) begin
            kb_ready_d = 1'b1;
            kb_data_d  = kbData;
        end else if (start_s && !rw && (mar_d == ADDR_KBDR)) begin
            kb_ready_d = 1'b0;
        end else begin
            kb_ready_d = kb_ready_q;
        end
        if (start_s && rw && (mar_d == ADDR_DDR)) begin
            ddr_out_d = mdr_bus_s[7:0];
            ddr_wr_d  = 1'b1;
        end else begin
            ddr_out_d = ddr_out_q;
            ddr_wr_d  = 1'b0;
        end
    end

    // Device registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kb_ready_q <= 1'b0;
            kb_data_q  <= 8'h00;
            ddr_out_q  <= 8'h00;
            ddr_wr_q   <= 1'b0;
        end else begin
            kb_ready_q <= kb_ready_d;
            kb_data_q  <= kb_data_d;
            ddr_out_q  <= ddr_out_d;
            ddr_wr_q   <= ddr_wr_d;
        end
    end

    assign ddrOut = ddr_out_q;
    assign ddrWr  = ddr_wr_q;
`endif

    assign MAROut   = mar_q;
    assign MDROut   = mdr_q;
    assign memAddr  = mar_q;
    assign memWdata = mdr_q;

endmodule
